// File: rtl/spi_seq_pkg.sv
// Shared types and default sizing for the SPI transaction sequencer.
package spi_seq_pkg;

    localparam int unsigned SPI_WORD_W      = 16;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_GAP_CYCLES  = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } seq_state_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Command queue for the sequencer: registered count, wrapping pointers,
// push refused whenever the registered count is full.
module spi_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_q];

    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Feeds queued 16-bit commands to the SPI master one at a time and returns the received word.
// Optional WAIT_DONE abort counter enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_vld,
    input  logic [SPI_WORD_W-1:0] req_cmd,
    output logic                  req_rdy,
    output logic                  spi_wrt,
    output logic [SPI_WORD_W-1:0] spi_cmd,
    input  logic                  spi_done,
    input  logic [SPI_WORD_W-1:0] spi_rdata,
    output logic                  rsp_vld,
    output logic [SPI_WORD_W-1:0] rsp_data,
    output logic                  rsp_err,
    input  logic                  rsp_rdy,
    output logic                  busy
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    seq_state_t            state_q, state_d;
    logic                  spi_wrt_q, spi_wrt_d;
    logic [SPI_WORD_W-1:0] spi_cmd_q, spi_cmd_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [SPI_WORD_W-1:0] rsp_data_q, rsp_data_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  fifo_pop_c, fifo_full, fifo_empty;
    logic [SPI_WORD_W-1:0] fifo_head;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign rsp_err    = 1'b0;
`endif

    spi_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SPI_WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_vld),
        .din   (req_cmd),
        .pop   (fifo_pop_c),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign req_rdy  = ~fifo_full;
    assign busy     = (state_q != IDLE) | ~fifo_empty;
    assign spi_wrt  = spi_wrt_q;
    assign spi_cmd  = spi_cmd_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        spi_wrt_d  = 1'b0;
        spi_cmd_d  = spi_cmd_q;
        rsp_vld_d  = rsp_vld_q & ~rsp_rdy;
        rsp_data_d = rsp_data_q;
        gap_d      = gap_q;
        fifo_pop_c = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
        tmo_d      = tmo_q;
        rsp_err_d  = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !rsp_vld_q) begin
                    state_d   = ISSUE;
                    spi_cmd_d = fifo_head;
                    spi_wrt_d = 1'b1;
                end
            end
            ISSUE: begin
                fifo_pop_c = 1'b1;
                state_d    = WAIT_DONE;
`ifdef SPI_SEQ_TIMEOUT_EN
                tmo_d      = '0;
`endif
            end
            WAIT_DONE: begin
                if (spi_done) begin
                    rsp_data_d = spi_rdata;
                    rsp_vld_d  = 1'b1;
                    gap_d      = '0;
                    state_d    = GAP;
`ifdef SPI_SEQ_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
                // ISSUE cycle plus TIMEOUT_CYC-1 WAIT_DONE cycles before the abort lands.
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 2)) begin
                    rsp_data_d = '0;
                    rsp_vld_d  = 1'b1;
                    rsp_err_d  = 1'b1;
                    gap_d      = '0;
                    state_d    = GAP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            spi_wrt_q  <= 1'b0;
            spi_cmd_q  <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            gap_q      <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_q      <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            spi_wrt_q  <= spi_wrt_d;
            spi_cmd_q  <= spi_cmd_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            gap_q      <= gap_d;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_q      <= tmo_d;
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Bench for spi_txn_sequencer with a behavioural SPI master/slave and a response scoreboard.
module tb_spi_txn_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP   = 8;
    localparam int unsigned LAT   = 12;
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int unsigned TMO   = 64;
`else
    localparam int unsigned TMO   = 1024;
`endif

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] sw;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n, req_vld, req_rdy, spi_wrt, spi_done, rsp_vld, rsp_err, rsp_rdy, busy;
    logic [15:0] req_cmd, spi_cmd, spi_rdata, rsp_data;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    vec_t iss_q[$];
    rsp_t exp_rsp_q[$];

    logic        master_en = 1'b1;
    logic        stale_done = 1'b0;
    logic        m_busy = 1'b0;
    logic        wrt_prev = 1'b0;
    logic        done_seen = 1'b0;
    logic        rsp_vld_prev = 1'b0;
    int          m_cnt = 0;
    int          wrt_cnt = 0;
    int          last_done_cyc = 0;
    int          last_wrt_cyc = 0;
    int          rise_cyc = 0;
    logic [15:0] m_rdata = '0;

    spi_txn_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .GAP_CYCLES  (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld   (req_vld),
        .req_cmd   (req_cmd),
        .req_rdy   (req_rdy),
        .spi_wrt   (spi_wrt),
        .spi_cmd   (spi_cmd),
        .spi_done  (spi_done),
        .spi_rdata (spi_rdata),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_rdy   (rsp_rdy),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SPI master + slave model: samples wrt on the falling edge, answers LAT cycles later.
    always @(negedge clk) begin
        vec_t cur;
        spi_done = 1'b0;
        if (!rst_n) begin
            m_busy    = 1'b0;
            done_seen = 1'b0;
            wrt_prev  = 1'b0;
        end else begin
            if (stale_done) begin
                spi_done   = 1'b1;
                spi_rdata  = 16'hBAD0;
                stale_done = 1'b0;
            end
            if (spi_wrt) begin
                check("wrt_one_cycle", 32'(wrt_prev), 32'd0);
                if (done_seen)
                    check("issue_gap_ok", 32'(cyc - last_done_cyc >= int'(GAP) + 2), 32'd1);
                if (iss_q.size() == 0) begin
                    check("wrt_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = iss_q.pop_front();
                    check("spi_cmd", 32'(spi_cmd), 32'(cur.cmd));
                    m_rdata = cur.sw;
                end
                m_busy       = 1'b1;
                m_cnt        = int'(LAT);
                wrt_cnt      = wrt_cnt + 1;
                last_wrt_cyc = cyc;
            end else if (m_busy && master_en) begin
                if (m_cnt == 0) begin
                    spi_done      = 1'b1;
                    spi_rdata     = m_rdata;
                    m_busy        = 1'b0;
                    last_done_cyc = cyc;
                    done_seen     = 1'b1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
            wrt_prev = spi_wrt;
        end
    end

    // Response monitor: pops the scoreboard on every accepted response.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n) begin
            if (rsp_vld && !rsp_vld_prev) rise_cyc = cyc;
            if (rsp_vld && rsp_rdy) begin
                if (exp_rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_rsp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (e.err) check("tmo_latency", 32'(rise_cyc - last_wrt_cyc), 32'(TMO));
                end
            end
        end
        rsp_vld_prev = rsp_vld;
    end

    task automatic push(input logic [15:0] cmd, input logic [15:0] sw, input logic err);
        int n = 0;
        rsp_t r;
        req_vld = 1'b1;
        req_cmd = cmd;
        while (!req_rdy && n < 500) begin
            step();
            n++;
        end
        check("push_rdy", 32'(req_rdy), 32'd1);
        iss_q.push_back('{cmd: cmd, sw: sw});
        r.data = err ? 16'h0000 : sw;
        r.err  = err;
        exp_rsp_q.push_back(r);
        step();
        req_vld = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_rsp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain", 32'(exp_rsp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_wrt"}, 32'(spi_wrt), 32'd0);
        check({tag, "_spi_cmd"}, 32'(spi_cmd), 32'd0);
        check({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_req_rdy"}, 32'(req_rdy), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int   w0;
        vecs[0] = '{cmd: 16'h70C3, sw: 16'h12EF};
        vecs[1] = '{cmd: 16'hFFFF, sw: 16'h0000};
        vecs[2] = '{cmd: 16'h0000, sw: 16'hFFFF};
        vecs[3] = '{cmd: 16'hA5A5, sw: 16'h5A5A};
        vecs[4] = '{cmd: 16'h8001, sw: 16'h7FFE};

        rst_n = 1'b0; req_vld = 1'b0; req_cmd = '0; rsp_rdy = 1'b1;
        spi_done = 1'b0; spi_rdata = '0;
        repeat (3) step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // Table-driven transactions, scoreboard compares responses in order.
        for (int i = 0; i < 5; i++) push(vecs[i].cmd, vecs[i].sw, 1'b0);
        wait_drain(1000);
        check("table_wrt_cnt", 32'(wrt_cnt), 32'd5);

        // Stalled response blocks issue; queue fills and refuses pushes.
        rsp_rdy = 1'b0;
        push(16'hA0A0, 16'h0A0A, 1'b0);
        for (int n = 0; n < 200 && !rsp_vld; n++) step();
        check("stall_rsp_vld", 32'(rsp_vld), 32'd1);
        push(16'hDEAD, 16'h1111, 1'b0);
        push(16'hBEEF, 16'h2222, 1'b0);
        push(16'h1234, 16'h3333, 1'b0);
        push(16'h5678, 16'h4444, 1'b0);
        check("full_req_rdy", 32'(req_rdy), 32'd0);
        w0 = wrt_cnt;
        for (int n = 0; n < 12; n++) begin
            step();
            check("stall_req_rdy", 32'(req_rdy), 32'd0);
            check("stall_rsp_data", 32'(rsp_data), 32'h0A0A);
        end
        check("stall_no_wrt", 32'(wrt_cnt), 32'(w0));

        // Release the response while pushing into a full queue across the pop edge.
        rsp_rdy = 1'b1;
        req_vld = 1'b1;
        req_cmd = 16'h9999;
        step();
        check("release_rsp_vld", 32'(rsp_vld), 32'd0);
        step();
        check("release_wrt", 32'(spi_wrt), 32'd1);
        check("release_cmd", 32'(spi_cmd), 32'hDEAD);
        check("full_at_pop", 32'(req_rdy), 32'd0);
        step();
        req_vld = 1'b0;
        check("after_pop_rdy", 32'(req_rdy), 32'd1);
        wait_drain(1000);
        repeat (20) step();
        check("refused_push_dropped", 32'(busy), 32'd0);
        check("b2b_wrt_cnt", 32'(wrt_cnt), 32'd10);

        // Reset mid-WAIT_DONE drops queued work; stale done is ignored.
        master_en = 1'b0;
        push(16'h4444, 16'h5555, 1'b0);
        push(16'h6666, 16'h7777, 1'b0);
        for (int n = 0; n < 50 && wrt_cnt == 10; n++) step();
        repeat (3) step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        iss_q.delete();
        exp_rsp_q.delete();
        step();
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        stale_done = 1'b1;
        master_en  = 1'b1;
        for (int n = 0; n < 15; n++) begin
            step();
            check("stale_rsp_vld", 32'(rsp_vld), 32'd0);
            check("stale_busy", 32'(busy), 32'd0);
        end

        // Minimum push-to-issue latency from idle and empty.
        w0 = wrt_cnt;
        push(16'h3C3C, 16'hC3C3, 1'b0);
        check("lat_cycle1_wrt", 32'(spi_wrt), 32'd0);
        step();
        check("lat_cycle2_wrt", 32'(spi_wrt), 32'd1);
        check("lat_cycle2_cmd", 32'(spi_cmd), 32'h3C3C);
        wait_drain(500);
        check("post_rst_wrt_cnt", 32'(wrt_cnt), 32'(w0 + 1));

`ifdef SPI_SEQ_TIMEOUT_EN
        // Master never answers: abort response, then normal traffic resumes.
        master_en = 1'b0;
        push(16'h5555, 16'hFFFF, 1'b1);
        wait_drain(500);
        m_busy    = 1'b0;
        master_en = 1'b1;
        push(16'h6666, 16'h1111, 1'b0);
        wait_drain(500);
`endif

        repeat (5) step();
        check("end_issue_q", 32'(iss_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
